// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: round-robin time slicing of one seven-segment display among NREQ requesters.
module seg7_display_arbiter #(
   parameter int NREQ        = 4,
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [32*NREQ-1:0] req_data,
   input  logic              freeze,
   output logic [NREQ-1:0]   o_grant,
   output logic              o_cs,
   output logic [31:0]       o_data,
   output logic              o_busy
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);
   typedef enum logic {IDLE, SHOW} state_t;
   state_t state;
   logic [CNT_W-1:0] cnt;
   logic [PW-1:0] ptr, win, idx;
   logic rearb;
   // Scan downward so the nearest requester after ptr is written last and wins.
   always_comb begin
      win = ptr;
      idx = ptr;
      for (int k = NREQ; k >= 1; k--) begin
         idx = PW'((int'(ptr) + k) % NREQ);
         if (req[idx]) win = idx;
      end
   end
   assign rearb = !req[ptr] || (cnt == '0 && !freeze);
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         o_grant <= '0;
         o_cs    <= 1'b0;
         o_data  <= '0;
         o_busy  <= 1'b0;
         cnt     <= '0;
         ptr     <= PW'(NREQ - 1);
      end else if (state == IDLE) begin
         o_cs <= 1'b0;
         if (|req) begin
            state   <= SHOW;
            o_busy  <= 1'b1;
            o_grant <= NREQ'(1) << win;
            ptr     <= win;
            cnt     <= RELOAD;
         end
      end else if (rearb && !(|req)) begin
         state   <= IDLE;
         o_busy  <= 1'b0;
         o_grant <= '0;
         o_cs    <= 1'b0;
      end else begin
         o_cs   <= 1'b1;
         o_data <= req_data[{ptr, 5'd0} +: 32];
         if (rearb) begin
            o_grant <= NREQ'(1) << win;
            ptr     <= win;
            cnt     <= RELOAD;
         end else if (!freeze) begin
            cnt <= cnt - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: scoreboard bench with a slice-level reference model of the arbiter.
module tb_seg7_display_arbiter;
   localparam int N = 4;
   localparam int H = 4;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] req = '0;
   logic [32*N-1:0] req_data = '0;
   logic [32*N-1:0] nd = '0;
   logic freeze = 1'b0;
   logic [N-1:0] o_grant;
   logic o_cs, o_busy;
   logic [31:0] o_data;

   seg7_display_arbiter #(.NREQ(N), .HOLD_CYCLES(H), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .freeze(freeze),
      .o_grant(o_grant), .o_cs(o_cs), .o_data(o_data), .o_busy(o_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0] g;
      logic         cs;
      logic [31:0]  d;
      logic         b;
   } exp_t;
   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model: who owns the display, how long it has been shown, last winner.
   int m_owner = -1;
   int m_last = N - 1;
   int m_age = 0;
   logic m_cs = 1'b0;
   logic [31:0] m_data = '0;

   function automatic int pick();
      for (int k = 1; k <= N; k++)
         if (req[(m_last + k) % N]) return (m_last + k) % N;
      return -1;
   endfunction

   task automatic grant_to(input int w);
      m_owner = w;
      m_last = w;
      m_age = 0;
   endtask

   task automatic step();
      exp_t e;
      int w;
      if (reset) begin
         m_owner = -1; m_last = N - 1; m_age = 0; m_cs = 1'b0; m_data = '0;
      end else if (m_owner < 0) begin
         m_cs = 1'b0;
         w = pick();
         if (w >= 0) grant_to(w);
      end else begin
         logic dropped, expired;
         dropped = !req[m_owner];
         expired = (m_age == H - 1) && !freeze;
         w = pick();
         if ((dropped || expired) && w < 0) begin
            m_owner = -1;
            m_cs = 1'b0;
         end else begin
            m_cs = 1'b1;
            m_data = req_data[32*m_owner +: 32];
            if (dropped || expired) grant_to(w);
            else if (!freeze) m_age++;
         end
      end
      e.g = (m_owner < 0) ? '0 : N'(1 << m_owner);
      e.cs = m_cs;
      e.d = m_data;
      e.b = (m_owner >= 0);
      q.push_back(e);
   endtask

   task automatic cyc(input logic r, input logic [N-1:0] rq, input logic f);
      @(posedge clk);
      #2;
      reset = r;
      req = rq;
      freeze = f;
      req_data = nd;
      step();
   endtask

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("grant", 32'(o_grant), 32'(e.g));
            chk("cs", 32'(o_cs), 32'(e.cs));
            chk("data", o_data, e.d);
            chk("busy", 32'(o_busy), 32'(e.b));
            chk("onehot0", 32'($onehot0(o_grant)), 32'd1);
         end
      end
   end

   initial begin
      // T1: reset then idle
      repeat (2) cyc(1, 4'b0000, 0);
      repeat (10) cyc(0, 4'b0000, 0);
      // T2: two requesters alternate
      nd[31:0] = 32'h11111111; nd[63:32] = 32'h33333333;
      nd[95:64] = 32'h22222222; nd[127:96] = 32'h44444444;
      repeat (14) cyc(0, 4'b0101, 0);
      repeat (2) cyc(0, 4'b0000, 0);
      // T3: lone requester keeps reloading
      repeat (12) cyc(0, 4'b0010, 0);
      // T4: owner drops mid-slice with and without a waiting requester
      repeat (2) cyc(1, 4'b0000, 0);
      cyc(0, 4'b0001, 0);
      cyc(0, 4'b1001, 0);
      repeat (6) cyc(0, 4'b1000, 0);
      repeat (2) cyc(0, 4'b0000, 0);
      repeat (3) cyc(0, 4'b0001, 0);
      repeat (3) cyc(0, 4'b0000, 0);
      // T5: freeze holds the owner, release resumes rotation
      repeat (2) cyc(0, 4'b0001, 0);
      repeat (20) cyc(0, 4'b1111, 1);
      repeat (20) cyc(0, 4'b1111, 0);
      // T6: reset mid-slice restarts the search at index 0
      repeat (3) cyc(0, 4'b0110, 0);
      cyc(1, 4'b0110, 0);
      repeat (8) cyc(0, 4'b0110, 0);
      // Random traffic with freeze, data changes and occasional reset
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] rq;
         if ($urandom_range(3) == 0) nd[32*$urandom_range(N-1) +: 32] = $urandom;
         rq = (i % 50 < 8) ? 4'b0000 : N'($urandom);
         cyc(($urandom_range(80) == 0), rq, ($urandom_range(7) == 0));
      end
      @(posedge clk);
      #3;
      chk("drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
